// File: rtl/counter8_jk_seq.sv
// 8-bit modulo counter (hold/up/down/load, 0..MOD_MAX) built from JK-style bit cells; 1-cycle latency.
// Optional COUNTER8_JK_EXCITE_OUT_EN exposes the per-bit J/K excitation as J_VEC/K_VEC.

module counter8_jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

module counter8_jk_seq #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [1:0] MODE,
  input  logic [7:0] D,
  input  logic [7:0] MOD_MAX,
  output logic [7:0] Q,
  output logic       TC,
`ifdef COUNTER8_JK_EXCITE_OUT_EN
  output logic       WRAP,
  output logic [7:0] J_VEC,
  output logic [7:0] K_VEC
`else
  output logic       WRAP
`endif
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [7:0] state;
  logic [7:0] next_state;
  logic       wrap_next;
  logic       active;
  logic       at_top;
  logic       at_zero;
  logic [7:0] j;
  logic [7:0] k;
  logic       wrap_r;

  assign active  = !RST && EN && (MODE != MODE_HOLD);
  assign at_top  = (state >= MOD_MAX);
  assign at_zero = (state == 8'h00);

  always_comb begin
    next_state = state;
    wrap_next  = 1'b0;
    if (active) begin
      case (MODE)
        MODE_UP: begin
          if (at_top) begin
            next_state = 8'h00;
            wrap_next  = 1'b1;
          end else begin
            next_state = state + 8'h01;
          end
        end
        MODE_DOWN: begin
          // An out-of-range count (e.g. after MOD_MAX shrinks) snaps to the limit without a wrap.
          if (at_zero) begin
            next_state = MOD_MAX;
            wrap_next  = 1'b1;
          end else if (state > MOD_MAX) begin
            next_state = MOD_MAX;
          end else begin
            next_state = state - 8'h01;
          end
        end
        MODE_LOAD: begin
          next_state = (D <= MOD_MAX) ? D : MOD_MAX;
        end
        default: begin
          next_state = state;
        end
      endcase
    end
  end

  // Excitation is derived from the target, so J and K are never both high.
  assign j = active ? (~state &  next_state) : 8'h00;
  assign k = active ? ( state & ~next_state) : 8'h00;

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_bit
      counter8_jk_cell u_cell (
        .clk     (CLK),
        .rst     (RST),
        .rst_val (RESET_VAL[i]),
        .j       (j[i]),
        .k       (k[i]),
        .q       (state[i])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= wrap_next;
    end
  end

  assign Q    = state;
  assign WRAP = wrap_r;
  assign TC   = !RST && EN &&
                (((MODE == MODE_UP) && at_top) || ((MODE == MODE_DOWN) && at_zero));

`ifdef COUNTER8_JK_EXCITE_OUT_EN
  assign J_VEC = j;
  assign K_VEC = k;
`endif

endmodule

// File: tb/tb_counter8_jk_seq.sv
// Self-checking bench for counter8_jk_seq: a behavioural model feeds a scoreboard queue of
// expected Q/WRAP per cycle; TC (and J/K when exposed) are checked combinationally before each edge.

module tb_counter8_jk_seq;

  localparam logic [7:0] RV = 8'hA5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic [7:0] D = 8'h00;
  logic [7:0] MOD_MAX = 8'h00;
  logic [7:0] Q;
  logic       TC;
  logic       WRAP;
`ifdef COUNTER8_JK_EXCITE_OUT_EN
  logic [7:0] J_VEC;
  logic [7:0] K_VEC;
`endif

  counter8_jk_seq #(.RESET_VAL(RV)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .MODE    (MODE),
    .D       (D),
    .MOD_MAX (MOD_MAX),
    .Q       (Q),
    .TC      (TC),
`ifdef COUNTER8_JK_EXCITE_OUT_EN
    .WRAP    (WRAP),
    .J_VEC   (J_VEC),
    .K_VEC   (K_VEC)
`else
    .WRAP    (WRAP)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] q;
    logic       wrap;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_q = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, push expectation, pop after edge.
  task automatic step(input logic rst, input logic en, input logic [1:0] mode,
                      input logic [7:0] d, input logic [7:0] mm, input string tag);
    exp_t       e;
    logic [7:0] n;
    logic       w;
    logic       tc;
    logic       act;
    @(negedge CLK);
    RST = rst; EN = en; MODE = mode; D = d; MOD_MAX = mm;
    #1;
    n   = m_q;
    w   = 1'b0;
    act = !rst && en && (mode != 2'b00);
    if (act) begin
      case (mode)
        2'b01: if (m_q >= mm) begin n = 8'h00; w = 1'b1; end else n = m_q + 8'h01;
        2'b10: if (m_q == 8'h00) begin n = mm; w = 1'b1; end
               else if (m_q > mm) n = mm;
               else n = m_q - 8'h01;
        default: n = (d <= mm) ? d : mm;
      endcase
    end
    tc = !rst && en && (((mode == 2'b01) && (m_q >= mm)) || ((mode == 2'b10) && (m_q == 8'h00)));
    check_val({tag, ".tc"}, {31'd0, TC}, {31'd0, tc});
`ifdef COUNTER8_JK_EXCITE_OUT_EN
    check_val({tag, ".j"}, {24'd0, J_VEC}, {24'd0, act ? (~m_q & n) : 8'h00});
    check_val({tag, ".k"}, {24'd0, K_VEC}, {24'd0, act ? (m_q & ~n) : 8'h00});
    check_val({tag, ".jk_excl"}, {24'd0, J_VEC & K_VEC}, 32'd0);
`endif
    if (rst) begin
      n = RV;
      w = 1'b0;
    end
    e.q    = n;
    e.wrap = w;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, ".q"}, {24'd0, Q}, {24'd0, e.q});
      check_val({tag, ".wrap"}, {31'd0, WRAP}, {31'd0, e.wrap});
      m_q = e.q;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state; operation inputs must be ignored while reset is high
    step(1'b1, 1'b1, 2'b01, 8'h00, 8'h05, "reset");
    step(1'b1, 1'b1, 2'b11, 8'h33, 8'h05, "reset_hold");

    // Unclamped reset value above MOD_MAX wraps to 0 on the first up count
    step(1'b0, 1'b1, 2'b01, 8'h00, 8'h05, "rv_wrap");

    // Up count 1..5 then wrap to 0 and continue
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 2'b01, 8'h00, 8'h05, "up_mod5");

    // Load above MOD_MAX clamps, then two down counts without wrap
    step(1'b0, 1'b1, 2'b11, 8'hC8, 8'h64, "load_clamp");
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'h64, "down1");
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'h64, "down2");

    // Load exactly MOD_MAX and a value below it
    step(1'b0, 1'b1, 2'b11, 8'h64, 8'h64, "load_eq");
    step(1'b0, 1'b1, 2'b11, 8'h00, 8'hFF, "load_zero");

    // Down from 0 with full range wraps to FF once
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'hFF, "down_wrap");
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'hFF, "down_after");

    // Hold via EN=0 and via MODE=00
    step(1'b0, 1'b0, 2'b01, 8'h00, 8'hFF, "hold_en");
    step(1'b0, 1'b1, 2'b00, 8'h12, 8'hFF, "hold_mode");

    // Shrinking MOD_MAX below the count: down snaps to limit, up wraps
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'h10, "down_snap");
    step(1'b0, 1'b1, 2'b11, 8'hF0, 8'hF0, "load_f0");
    step(1'b0, 1'b1, 2'b01, 8'h00, 8'h20, "up_over");

    // MOD_MAX=0: every enabled count cycle wraps, back to back
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b01, 8'h00, 8'h00, "mm0_up");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, "mm0_down");

    // Reset mid-count at Q=3 discards the pending up count
    step(1'b0, 1'b1, 2'b11, 8'h02, 8'h09, "load2");
    step(1'b0, 1'b1, 2'b01, 8'h00, 8'h09, "up_to3");
    step(1'b1, 1'b1, 2'b01, 8'h00, 8'h09, "rst_mid");
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'hFF, "resume");

    // Excitation pattern from Q=07 counting up
    step(1'b0, 1'b1, 2'b11, 8'h07, 8'hFF, "load7");
    step(1'b0, 1'b1, 2'b01, 8'h00, 8'hFF, "up_from7");

    // Random traffic with occasional resets
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] mm;
      mm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom), 8'($urandom), mm, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
